key_dispatcher: RTL
===================

Name: key_dispatcher

Overview:
- Schedules the RC4 brute-force key search across NUM_CORES decrypt cores.
- Each core runs the init, shuffle and decrypt sequence on one key, then reports done/success.
- The dispatcher assigns successive candidate keys round-robin to idle cores and tracks which cores are busy.
- On the first success it broadcasts stop and latches the winning key; if the keyspace runs out with no success, it reports exhaustion.

Parameters:
- NUM_CORES, 4, number of decrypt cores served (1..16).
- KEY_W, 24, candidate key width.
- KEY_MAX, 24'h3FFFFF, last key in the search space (inclusive).
- TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a search from key 0.
- core_start  out  NUM_CORES  one-cycle pulse per core; the core begins on the key in core_key.
- core_key  out  NUM_CORES*KEY_W  key assigned to each core; slice i is held stable while core i is busy.
- core_done  in  NUM_CORES  one-cycle pulse from a core when its key attempt finishes.
- core_success  in  NUM_CORES  qualifies core_done; 1 means the decrypted message was valid.
- stop_all  out  1  level output; all cores abort.
- found  out  1  level output; a key was found.
- found_key  out  KEY_W  the winning key, valid while found=1.
- exhausted  out  1  level output; keyspace finished with no success.
- busy  out  1  high while a search is in progress.
- keys_tried  out  KEY_W+1  count of completed key attempts.
- timeout_cnt  out  8  count of keys abandoned by the watchdog (saturating).

Behaviour:
- Reset (async, reset=1): all outputs 0, state IDLE, next_key=0, busy bits 0, round-robin pointer 0.
- States: IDLE, DISPATCH, DRAIN, DONE_OK, DONE_FAIL.
- IDLE:
  - start=1 → DISPATCH, with next_key=0 and keys_tried=0.
  - found, exhausted and stop_all clear when this transition happens.
- DISPATCH, each cycle:
  - At most one core is started per cycle.
  - Pick the first idle core at or after the round-robin pointer, wrapping modulo NUM_CORES.
  - Drive core_start[i]=1 and core_key[i]=next_key; set busy[i]; next_key++; pointer=i+1 (wraps).
  - Latency: start → first core_start is 1 cycle. A single core's done → its re-dispatch is 1 cycle.
- Completion handling (DISPATCH and DRAIN):
  - core_done[i] with busy[i]=1: clear busy[i]; keys_tried++.
  - core_done[i] with busy[i]=0: ignored.
  - A core receiving done in cycle t is not eligible for dispatch before t+1.
  - Multiple done pulses in one cycle: keys_tried adds the popcount.
- Success:
  - Any valid done with success → DONE_OK next cycle: found=1, stop_all=1, found_key=core_key of the winner.
  - Simultaneous successes: the lowest index wins.
  - No further core_start pulses after a success.
- Keyspace end:
  - After the core with key KEY_MAX is dispatched, go to DRAIN. next_key does not wrap; its width is KEY_W+1.
  - DRAIN: wait until all busy bits are 0 → DONE_FAIL: exhausted=1.
  - A success during DRAIN still goes to DONE_OK.
- Terminal states:
  - DONE_OK and DONE_FAIL hold their outputs.
  - start → clear found/exhausted/stop_all, go to DISPATCH from key 0.
- busy output = 1 in DISPATCH and DRAIN.
- start is ignored in DISPATCH and DRAIN.
- Reset mid-search returns to the reset values immediately; cores are reset separately.

Optional Feature:
- Macro: KEY_DISPATCH_TIMEOUT_EN.
- Defined:
  - Each core has a counter that clears on dispatch and increments while the core is busy.
  - At TIMEOUT the core's busy bit clears, keys_tried increments, timeout_cnt increments (saturating at 255), and the key is treated as a failure.
  - A core_done from that core arriving later is ignored, because the core is no longer busy.
- Not defined: no counters; timeout_cnt is tied to 0.

Decomposition:
- Package key_dispatch_pkg holds:
  - the state enum (IDLE, DISPATCH, DRAIN, DONE_OK, DONE_FAIL);
  - KEY_W_DEFAULT and KEY_MAX_DEFAULT.
- One sub-module, rr_pick: combinational round-robin first-idle picker.
  - Inputs: idle mask, pointer.
  - Outputs: grant one-hot, grant index, valid.

Test Plan:
- Single success: NUM_CORES=4, KEY_MAX=15; core 2 reports success on key 6.
  - Required: found=1, found_key=6, stop_all=1, no core_start after that point.
- Exhaustion: KEY_MAX=9, all cores fail.
  - Required: keys 0..9 each dispatched exactly once; exhausted=1 only after the last done; keys_tried=10.
- Simultaneous success: cores 1 and 3 succeed in the same cycle on keys 5 and 7.
  - Required: found_key=5.
- Same-cycle done and re-dispatch: core 0 done at cycle t while the other cores are busy.
  - Required: core_start[0] at t+1, not at t.
- Reset mid-search: assert reset during DISPATCH.
  - Required: all outputs 0 asynchronously; a following start restarts from key 0.
- Watchdog (with KEY_DISPATCH_TIMEOUT_EN, TIMEOUT=8): core 1 never reports done.
  - Required: busy[1] clears after 8 cycles, timeout_cnt=1, core 1 re-dispatched with the next key, and a late core_done[1] is ignored.

Source files
------------

// File: rtl/key_dispatch_pkg.sv
// Shared types and defaults for the RC4 key-search dispatcher.
package key_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE_OK,
    DONE_FAIL
  } state_e;

  localparam int KEY_W_DEFAULT = 24;
  localparam logic [KEY_W_DEFAULT-1:0] KEY_MAX_DEFAULT = 24'h3FFFFF;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_dispatcher_rr_pick.sv
// Round-robin first-idle picker: searches from ptr upwards, wrapping modulo N,
// and grants the first core whose idle bit is set.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     idle,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  // Scan N positions starting at ptr; the first idle one wins.
  always_comb begin
    int j;
    // NOTE: every output gets a value before the loop so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && idle[j]) begin
        valid     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/key_dispatcher.sv
// Key dispatcher for the RC4 brute-force search: hands successive keys to idle
// decrypt cores round-robin, counts completed attempts, latches the first
// winning key and reports exhaustion when the keyspace runs out.
// Optional watchdog: define KEY_DISPATCH_TIMEOUT_EN to abandon keys whose core
// stays busy for TIMEOUT cycles.
module key_dispatcher
  import key_dispatch_pkg::*;
#(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_MAX   = KEY_W'(KEY_MAX_DEFAULT),
  parameter int               TIMEOUT   = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_success,
  output logic                       stop_all,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic                       exhausted,
  output logic                       busy,
  output logic [KEY_W:0]             keys_tried,
  output logic [7:0]                 timeout_cnt
);

  localparam int IDX_W = idx_width(NUM_CORES);

  if (NUM_CORES < 1 || NUM_CORES > 16 || TIMEOUT < 1) begin : g_cfg_check
    $error("key_dispatcher: NUM_CORES must be 1..16 and TIMEOUT at least 1");
  end

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [KEY_W:0]       next_key_q, next_key_d;
  logic [KEY_W:0]       keys_tried_q, keys_tried_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [KEY_W-1:0]     found_key_q, found_key_d;
  logic [KEY_W-1:0]     key_q [NUM_CORES];

  logic                 running, launch, dispatch;
  logic [NUM_CORES-1:0] grant, finish, expire;
  logic [IDX_W-1:0]     grant_idx, win_idx;
  logic                 grant_valid, win_valid;
  logic [KEY_W:0]       n_finish;

  assign running = (state_q == DISPATCH) || (state_q == DRAIN);
  assign launch  = start && !running;

  rr_pick #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .idle      (~busy_q),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  // A success in the current cycle suppresses dispatch so no core starts once a key is found.
  assign dispatch   = (state_q == DISPATCH) && grant_valid && !win_valid;
  assign core_start = dispatch ? grant : '0;

  // Completions: count finished attempts and find the lowest-index successful core.
  always_comb begin
    finish    = running ? (busy_q & (core_done | expire)) : '0;
    win_valid = 1'b0;
    win_idx   = '0;
    n_finish  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n_finish = n_finish + (KEY_W+1)'(finish[i]);
      if (!win_valid && running && busy_q[i] && core_done[i] && core_success[i]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state and bookkeeping for the search.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q & ~finish;
    next_key_d   = next_key_q;
    keys_tried_d = keys_tried_q + n_finish;
    ptr_d        = ptr_q;
    found_key_d  = found_key_q;

    if (dispatch) begin
      busy_d     = busy_d | grant;
      next_key_d = next_key_q + (KEY_W+1)'(1);
      ptr_d      = (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    case (state_q)
      DISPATCH: begin
        if (win_valid) begin
          state_d     = DONE_OK;
          found_key_d = key_q[win_idx];
          busy_d      = '0;
        end else if (dispatch && next_key_q == {1'b0, KEY_MAX}) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (win_valid) begin
          state_d     = DONE_OK;
          found_key_d = key_q[win_idx];
          busy_d      = '0;
        end else if (busy_d == '0) begin
          state_d = DONE_FAIL;
        end
      end
      default: begin
        if (launch) begin
          state_d      = DISPATCH;
          next_key_d   = '0;
          keys_tried_d = '0;
          busy_d       = '0;
          ptr_d        = '0;
          found_key_d  = '0;
        end
      end
    endcase
  end

  // Search state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= '0;
      next_key_q   <= '0;
      keys_tried_q <= '0;
      ptr_q        <= '0;
      found_key_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      busy_q       <= busy_d;
      next_key_q   <= next_key_d;
      keys_tried_q <= keys_tried_d;
      ptr_q        <= ptr_d;
      found_key_q  <= found_key_d;
    end
  end

  // Per-core key slots, loaded on dispatch and held while the core works.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this small array drives core_key directly, so it is reset to keep outputs at 0.
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_start[i]) key_q[i] <= next_key_q[KEY_W-1:0];
      end
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_key
    assign core_key[i*KEY_W +: KEY_W] = core_start[i] ? next_key_q[KEY_W-1:0] : key_q[i];
  end

`ifdef KEY_DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wd_q [NUM_CORES];
  logic [7:0]      timeout_q;
  logic [8:0]      timeout_sum;

  // A core expires on its TIMEOUT-th busy cycle.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      expire[i] = busy_q[i] && (wd_q[i] == TO_W'(TIMEOUT - 1));
    end
  end

  // Watchdog counters: cleared on dispatch, advance while the core is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) wd_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_start[i])              wd_q[i] <= '0;
        else if (running && busy_q[i])  wd_q[i] <= wd_q[i] + TO_W'(1);
      end
    end
  end

  // Abandoned keys are those that expired without a done in the same cycle.
  always_comb begin
    timeout_sum = {1'b0, timeout_q};
    for (int i = 0; i < NUM_CORES; i++) begin
      timeout_sum = timeout_sum + 9'(finish[i] & expire[i] & ~core_done[i]);
    end
  end

  // Saturating abandoned-key counter, restarted with each search.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       timeout_q <= '0;
    else if (launch) timeout_q <= '0;
    else             timeout_q <= timeout_sum[8] ? 8'hFF : timeout_sum[7:0];
  end

  assign timeout_cnt = timeout_q;
`else
  assign expire      = '0;
  assign timeout_cnt = '0;
`endif

  assign busy       = running;
  assign found      = (state_q == DONE_OK);
  assign stop_all   = (state_q == DONE_OK);
  assign exhausted  = (state_q == DONE_FAIL);
  assign found_key  = found_key_q;
  assign keys_tried = keys_tried_q;

endmodule
